// File: rtl/dma_burst_sched_if.sv
// Address-channel handshake bundle between the requesting clusters, the
// burst scheduler and the downstream DMA multiplexer.
interface dma_burst_sched_if #(
  parameter int NumClusters = 4,
  parameter int SelWidth    = (NumClusters > 1) ? $clog2(NumClusters) : 1
);
  logic [NumClusters-1:0] req_valid;
  logic [NumClusters-1:0] req_ready;
  logic                   mst_valid;
  logic [SelWidth-1:0]    mst_sel;
  logic                   mst_ready;

  // master: the scheduler, which owns the forwarded request toward the mux
  modport master (
    input  req_valid,
    input  mst_ready,
    output req_ready,
    output mst_valid,
    output mst_sel
  );

  modport slave (
    output req_valid,
    output mst_ready,
    input  req_ready,
    input  mst_valid,
    input  mst_sel
  );
endinterface

// File: rtl/dma_burst_sched.sv
// Round-robin scheduler with per-holder grant quantum and per-cluster
// outstanding-transaction caps for the shared cluster-DMA path to L2.
module dma_burst_sched #(
  parameter int NumClusters    = 4,
  parameter int MaxOutstanding = 8,
  parameter int Quantum        = 4,
  parameter int CntWidth       = $clog2(MaxOutstanding + 1),
  parameter int SelWidth       = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [NumClusters-1:0]          cpl_i,
  output logic [NumClusters*CntWidth-1:0] outstanding_o,
  output logic                            busy_o,
  output logic                            err_o,
  dma_burst_sched_if.master               bus
);

  localparam int                 QWidth   = $clog2(Quantum + 1);
  localparam logic [QWidth-1:0]  QuantumQ = QWidth'(Quantum);
  localparam logic [CntWidth-1:0] MaxQ    = CntWidth'(MaxOutstanding);
  localparam logic [SelWidth-1:0] LastIdx = SelWidth'(NumClusters - 1);

  logic [SelWidth-1:0] r_ptr;
  logic [QWidth-1:0]   r_used;
  logic                r_lock;
  logic [SelWidth-1:0] r_lsel;
  logic [CntWidth-1:0] r_cnt [NumClusters];
  logic                r_err;

  logic [NumClusters-1:0] w_elig;
  logic [NumClusters-1:0] w_grant;
  logic [SelWidth-1:0]    w_scan_sel;
  logic [SelWidth-1:0]    w_sel;
  logic [SelWidth-1:0]    w_sel_out;
  logic                   w_valid;
  logic                   w_hs;
  logic                   w_busy;

  function automatic logic [SelWidth-1:0] wrap_add(input logic [SelWidth-1:0] base,
                                                   input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NumClusters)) s = s - 32'(NumClusters);
    return s[SelWidth-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NumClusters; i++) begin
      w_elig[i] = bus.req_valid[i] && (r_cnt[i] < MaxQ);
    end
  end

  // Scan from the far end back toward ptr+1 so the last hit is the nearest one.
  always_comb begin
    w_scan_sel = '0;
    for (int k = NumClusters; k >= 1; k--) begin
      if (w_elig[wrap_add(r_ptr, k)]) w_scan_sel = wrap_add(r_ptr, k);
    end
  end

  always_comb begin
    w_sel     = (w_elig[r_ptr] && (r_used < QuantumQ)) ? r_ptr : w_scan_sel;
    w_valid   = !rst_i && (r_lock || (en_i && (|w_elig)));
    w_sel_out = rst_i ? '0 : (r_lock ? r_lsel : w_sel);
    w_hs      = w_valid && bus.mst_ready;
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NumClusters; i++) begin
      w_grant[i] = w_hs && (w_sel_out == SelWidth'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr  <= LastIdx;
      r_used <= QuantumQ;
      r_lock <= 1'b0;
      r_lsel <= '0;
      r_err  <= 1'b0;
      for (int i = 0; i < NumClusters; i++) r_cnt[i] <= '0;
    end else begin
      if (w_hs) begin
        r_lock <= 1'b0;
        if ((w_sel_out == r_ptr) && (r_used < QuantumQ)) begin
          r_used <= r_used + QWidth'(1);
        end else begin
          r_ptr  <= w_sel_out;
          r_used <= QWidth'(1);
        end
      end else if (w_valid) begin
        r_lock <= 1'b1;
        r_lsel <= w_sel_out;
      end

      // A completion on an empty counter means a lost or stale transaction.
      for (int i = 0; i < NumClusters; i++) begin
        case ({w_grant[i], cpl_i[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CntWidth'(1);
          2'b01: begin
            if (r_cnt[i] == '0) r_err    <= 1'b1;
            else                r_cnt[i] <= r_cnt[i] - CntWidth'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NumClusters; i++) begin
      outstanding_o[i*CntWidth +: CntWidth] = r_cnt[i];
      w_busy = w_busy | (r_cnt[i] != '0);
    end
  end

  assign bus.mst_valid = w_valid;
  assign bus.mst_sel   = w_sel_out;
  assign bus.req_ready = w_grant;
  assign busy_o        = w_busy;
  assign err_o         = r_err;

endmodule
